alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator-side controller for the team's combinational 16-bit ALU (sixteen_bit_alu). It accepts register-level commands over a valid/ready handshake and reads operands from an internal 8x16 register file. It drives registered a/b/op into the ALU, captures the ALU result, writes it back, and returns it over a valid/ready response channel. One command is in flight at a time.

Parameters:
WIDTH, 16, datapath width; fixed to match the ALU.
REG_AW, 3, register-file address width (2**REG_AW registers; r0 reads as zero).
CNT_W, 16, width of the completed-command counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  4  ALU opcode.
cmd_rd  input  REG_AW  destination register.
cmd_ra  input  REG_AW  source A register.
cmd_rb  input  REG_AW  source B register.
cmd_imm_sel  input  1  1: B operand = cmd_imm; 0: B operand = reg[cmd_rb].
cmd_imm  input  WIDTH  immediate.
alu_a  output  WIDTH  to ALU a.
alu_b  output  WIDTH  to ALU b.
alu_op  output  4  to ALU op.
alu_out  input  WIDTH  from ALU out; combinational in alu_a/alu_b/alu_op.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_data  output  WIDTH  result.
rsp_rd  output  REG_AW  destination of result.
rsp_err  output  1  opcode was illegal.
done_cnt  output  CNT_W  count of completed responses.

Behaviour:
- Legal opcodes: 0000 sub, 0001 add, 0010 or, 0011 and, 0100 dec, 0101 inc, 0110 inv, 1000 lsl, 1001 slt, 1010 lsr, 1100 asl, 1110 asr. Illegal: 0111, 1011, 1101, 1111.
- FSM states: IDLE, EXEC, RESP. cmd_ready = (state==IDLE), combinational from state only.
- IDLE: on cmd_valid at a rising edge, the command is accepted. In the same edge:
  - alu_a <= reg[cmd_ra] (0 if cmd_ra==0).
  - alu_b <= cmd_imm_sel ? cmd_imm : reg[cmd_rb] (0 if cmd_rb==0).
  - alu_op <= cmd_op; rd and err latched; state -> EXEC.
- EXEC (exactly 1 cycle): at the next edge:
  - rsp_data <= err ? 0 : alu_out; rsp_rd <= rd; rsp_err <= err; rsp_valid <= 1.
  - reg[rd] <= alu_out only if !err and rd!=0.
  - state -> RESP.
- RESP: rsp_valid, rsp_data, rsp_rd and rsp_err are held stable until rsp_valid && rsp_ready at an edge. At that edge: rsp_valid <= 0, done_cnt <= done_cnt+1 (wraps modulo 2**CNT_W), state -> IDLE.
- Latency: accept edge to rsp_valid high = 2 edges. Minimum issue interval = 3 cycles with rsp_ready held high.
- Because only one command is in flight and write-back occurs before the next accept, there are no read-after-write hazards. A command that reads the previous rd sees the new value.
- alu_a, alu_b and alu_op hold their last values outside EXEC.
- Writes to r0 are discarded; r0 always reads 0.
- Arithmetic wraps modulo 2**WIDTH as produced by the ALU. The sequencer does not alter the result.
- Reset (rst_n low, any time, including mid-EXEC/RESP), asynchronous:
  - state = IDLE; cmd_ready = 1.
  - rsp_valid = 0, rsp_err = 0, rsp_data = 0, rsp_rd = 0.
  - alu_a = 0, alu_b = 0, alu_op = 0000.
  - All registers = 0; done_cnt = 0.
  - An in-flight command is dropped: no write-back, no response.
- cmd_valid while not IDLE is ignored; the command is not consumed.
- rsp_ready while rsp_valid is low has no effect.

Test Plan:
- Reset then cmd(add, rd=1, ra=0, imm_sel=1, imm=0x0005) -> rsp_valid 2 edges after accept, rsp_data=0x0005, rsp_rd=1, rsp_err=0; done_cnt=1.
- With r1=5: cmd(sub, rd=2, ra=1, imm=7), then cmd(add, rd=3, ra=2, rb=2, imm_sel=0) -> rsp_data=0xFFFE, then 0xFFFC (wrap).
- cmd(op=0111, rd=1) -> rsp_err=1, rsp_data=0; a following cmd(add, rd=4, ra=1, imm=0) returns 0x0005, proving r1 unchanged.
- rsp_ready low for 4 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0, a presented cmd is not accepted; rsp_ready high -> handshake, cmd_ready=1 next cycle.
- cmd(inc, rd=0, ra=0) -> rsp_data=0x0001; a follow-up read of r0 returns 0x0000.
- Assert rst_n low during EXEC -> immediately rsp_valid=0, alu_op=0000, cmd_ready=1; no response after release; done_cnt=0; r1 reads 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit combinational ALU: reads operands from a small
// register file, drives the ALU for one cycle, writes back and returns the result.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_op_i,
    input  logic [REG_AW-1:0] cmd_rd_i,
    input  logic [REG_AW-1:0] cmd_ra_i,
    input  logic [REG_AW-1:0] cmd_rb_i,
    input  logic              cmd_imm_sel_i,
    input  logic [WIDTH-1:0]  cmd_imm_i,
    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    output logic [3:0]        alu_op_o,
    input  logic [WIDTH-1:0]  alu_out_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic [REG_AW-1:0] rsp_rd_o,
    output logic              rsp_err_o,
    output logic [CNT_W-1:0]  done_cnt_o
);

    localparam int unsigned NumRegs = 1 << REG_AW;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]  rf_q [NumRegs];
    logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [REG_AW-1:0] rsp_rd_q, rsp_rd_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
    logic              wb_en;
    logic              accept;
    logic              op_illegal;
    logic [WIDTH-1:0]  rd_a, rd_b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_valid_i) state_d = StExec;
            StExec: state_d = StResp;
            StResp: if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready_o = (state_q == StIdle);
    end

    always_comb begin
        unique case (cmd_op_i)
            4'b0111, 4'b1011, 4'b1101, 4'b1111: op_illegal = 1'b1;
            default:                            op_illegal = 1'b0;
        endcase
    end

    // r0 is never written, but the explicit mux keeps it zero regardless.
    assign rd_a   = (cmd_ra_i == '0) ? '0 : rf_q[cmd_ra_i];
    assign rd_b   = (cmd_rb_i == '0) ? '0 : rf_q[cmd_rb_i];
    assign accept = (state_q == StIdle) && cmd_valid_i;

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        done_cnt_d  = done_cnt_q;
        wb_en       = 1'b0;
        if (accept) begin
            alu_a_d  = rd_a;
            alu_b_d  = cmd_imm_sel_i ? cmd_imm_i : rd_b;
            alu_op_d = cmd_op_i;
            rd_d     = cmd_rd_i;
            err_d    = op_illegal;
        end
        if (state_q == StExec) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = err_q ? '0 : alu_out_i;
            rsp_rd_d    = rd_q;
            rsp_err_d   = err_q;
            wb_en       = !err_q && (rd_q != '0);
        end
        if ((state_q == StResp) && rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
            done_cnt_d  = done_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[rd_q] <= alu_out_i;
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_rd_o    = rsp_rd_q;
    assign rsp_err_o   = rsp_err_q;
    assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU stands in for the real one, and a
// register-file/counter model predicts every operand, response and count.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [2:0]  cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic        cmd_imm_sel = 1'b0;
    logic [15:0] cmd_imm = '0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_rd;
    logic        rsp_err;
    logic [15:0] done_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_rf [8];
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(16), .REG_AW(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_rd_i     (cmd_rd),
        .cmd_ra_i     (cmd_ra),
        .cmd_rb_i     (cmd_rb),
        .cmd_imm_sel_i(cmd_imm_sel),
        .cmd_imm_i    (cmd_imm),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_out_i    (alu_out),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_rd_o     (rsp_rd),
        .rsp_err_o    (rsp_err),
        .done_cnt_o   (done_cnt)
    );

    // Illegal opcodes return a recognisable non-zero value so a leaked result shows up.
    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            4'd0:    return a - b;
            4'd1:    return a + b;
            4'd2:    return a | b;
            4'd3:    return a & b;
            4'd4:    return a - 16'd1;
            4'd5:    return a + 16'd1;
            4'd6:    return ~a;
            4'd8:    return a << 1;
            4'd9:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd10:   return a >> 1;
            4'd12:   return a << 1;
            4'd14:   return 16'($signed(a) >>> 1);
            default: return 16'hDEAD;
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_op, alu_a, alu_b);

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'd7) || (op == 4'd11) || (op == 4'd13) || (op == 4'd15);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_cnt = '0;
    endtask

    // Entered and left at 1 time unit after a rising edge, with the DUT idle.
    task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic [2:0] rb, input logic sel, input logic [15:0] imm,
                           input int stall);
        logic [15:0] ea, eb, er;
        logic        ill;
        ea  = m_rf[ra];
        eb  = sel ? imm : m_rf[rb];
        ill = is_illegal(op);
        er  = ill ? 16'd0 : alu_f(op, ea, eb);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        cmd_imm_sel = sel; cmd_imm = imm; cmd_valid = 1'b1;
        rsp_ready = 1'($urandom);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_imm = 16'($urandom); cmd_ra = 3'($urandom); cmd_rb = 3'($urandom);
        rsp_ready = 1'($urandom);
        check_eq("exec_ready", 32'(cmd_ready), 32'd0);
        check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("alu_a", 32'(alu_a), 32'(ea));
        check_eq("alu_b", 32'(alu_b), 32'(eb));
        check_eq("alu_op", 32'(alu_op), 32'(op));
        @(posedge clk); #1;
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_data", 32'(rsp_data), 32'(er));
        check_eq("rsp_rd", 32'(rsp_rd), 32'(rd));
        check_eq("rsp_err", 32'(rsp_err), 32'(ill));
        if (!ill && rd != 3'd0) m_rf[rd] = er;
        rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            // A competing command during RESP must be ignored.
            cmd_valid = 1'($urandom); cmd_op = 4'($urandom); cmd_rd = 3'($urandom);
            cmd_ra = 3'($urandom); cmd_imm = 16'($urandom);
            @(posedge clk); #1;
            check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("stall_rsp_data", 32'(rsp_data), 32'(er));
            check_eq("stall_ready", 32'(cmd_ready), 32'd0);
            check_eq("stall_alu_a", 32'(alu_a), 32'(ea));
            check_eq("stall_done_cnt", 32'(done_cnt), 32'(m_cnt));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_cnt = m_cnt + 16'd1;
        check_eq("hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("hs_ready", 32'(cmd_ready), 32'd1);
        check_eq("done_cnt", 32'(done_cnt), 32'(m_cnt));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_alu_a", 32'(alu_a), 32'd0);
        check_eq("rst_alu_b", 32'(alu_b), 32'd0);
        check_eq("rst_alu_op", 32'(alu_op), 32'd0);
        check_eq("rst_done_cnt", 32'(done_cnt), 32'd0);

        run_cmd(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 0);   // r1 = 5
        run_cmd(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0007, 0);   // r2 = 0xFFFE
        run_cmd(4'd1, 3'd3, 3'd2, 3'd2, 1'b0, 16'h1234, 0);   // r3 = 0xFFFC
        run_cmd(4'd7, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001, 0);   // illegal, r1 kept
        run_cmd(4'd1, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0000, 4);   // reads 5, 4-cycle stall
        run_cmd(4'd5, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0000, 0);   // inc into r0 -> 1
        run_cmd(4'd1, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0000, 0);   // r0 still 0

        // Reset while a command sits in EXEC.
        cmd_op = 4'd1; cmd_rd = 3'd1; cmd_ra = 3'd1; cmd_imm_sel = 1'b1;
        cmd_imm = 16'h00F0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("midrst_alu_op", 32'(alu_op), 32'd0);
        check_eq("midrst_alu_a", 32'(alu_a), 32'd0);
        check_eq("midrst_ready", 32'(cmd_ready), 32'd1);
        check_eq("midrst_done_cnt", 32'(done_cnt), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("postrst_done_cnt", 32'(done_cnt), 32'd0);
        end
        rsp_ready = 1'b0;
        run_cmd(4'd1, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0000, 0);   // r1 was cleared

        for (int n = 0; n < 150; n++) begin
            logic [15:0] imm;
            case ($urandom_range(0, 5))
                0:       imm = 16'h0000;
                1:       imm = 16'hFFFF;
                2:       imm = 16'h8000;
                default: imm = 16'($urandom);
            endcase
            run_cmd(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                    imm, int'($urandom_range(0, 3)));
            // Idle gap: stray rsp_ready with no response pending must not count.
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                rsp_ready = 1'($urandom);
                @(posedge clk); #1;
                check_eq("idle_done_cnt", 32'(done_cnt), 32'(m_cnt));
                check_eq("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            end
            rsp_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
